branch_metric_unit: RTL and testbench
=====================================

# branch_metric_unit

Radix-4 branch metric unit for the Viterbi decoder path. It sits directly downstream of the convolutional encoder/trellis table and upstream of the add-compare-select stage. Each accepted received symbol group produces one sweep of metrics, one per codeword hypothesis, streamed out with valid/ready. Received groups are buffered in a 2-entry FIFO so the upstream channel is not stalled during a sweep.

## Interface
- No parameters; widths are fixed, and soft decision is selected by macro (see Configuration).
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- en_bm  input  1  block enable; low freezes all state
- mode_select  input  1  code rate: 0 = rate 1/2 (4-bit codeword per radix-4 step), 1 = rate 1/3 (6-bit codeword)
- rx_valid  input  1  received group valid
- rx_ready  output  1  FIFO can accept a group
- rx_sym  input  6 (hard) / 18 (soft)  received bits; bit i is at [i] (hard) or [3i+2:3i] (soft)
- bm_ready  input  1  downstream accepts the current metric
- bm_valid  output  1  metric valid
- bm_addr  output  6  codeword hypothesis; bit i is compared with received bit i
- bm_value  output  6  branch metric, zero-extended
- bm_last  output  1  marks the final hypothesis of the sweep

## Operation
- **Input FIFO**
  - 2 entries deep; each entry stores rx_sym.
  - A push occurs when rx_valid & rx_ready.
  - rx_ready = en_bm & (FIFO count < 2), taken from registered state only; it has no combinational dependence on pops.
- **FSM states:** IDLE and SWEEP.
- **IDLE**
  - If en_bm and the FIFO is not empty: pop the head into the working register sym_r.
  - Latch mode_select into mode_r.
  - Set addr to 0 and enter SWEEP.
- **SWEEP**
  - The output beat is {bm_addr = addr, bm_value = metric(sym_r, addr), bm_last = (addr == lim)}, where lim = 15 if mode_r = 0 and 63 if mode_r = 1.
  - On transfer (bm_valid & bm_ready), addr increments.
  - On a transfer with bm_last:
    - If the FIFO is not empty: pop, reload sym_r/mode_r, set addr to 0 and stay in SWEEP (zero-bubble back-to-back).
    - Otherwise go to IDLE.
- **Hard metric:** Hamming distance between addr and sym_r over N bits (N = 4 or 6). Range 0..6.
- **Soft metric:** sum over i < N of (addr[i] ? 7 - s_i : s_i), where s_i is the 3-bit sample (0 = strong 0, 7 = strong 1). Range 0..42.
- **Rate 1/2 inputs:** rx_sym bits beyond N are ignored, and bm_addr[5:4] = 0.
- **mode_select changes:** a change mid-sweep does not affect the running sweep; it applies at the next sweep load.
- **en_bm low:**
  - No push, no pop, addr held, FSM held.
  - bm_valid forced to 0; the outputs resume unchanged when en_bm returns high.
- **Simultaneous push and pop:** allowed (count unchanged). Pop data is always the oldest entry.

## Timing
- All outputs are registered.
- Reset values:
  - rx_ready = 0 during reset, then 1 on the cycle after reset is released (with en_bm high).
  - bm_valid = 0, bm_addr = 0, bm_value = 0, bm_last = 0.
  - FIFO empty, FSM in IDLE.
- **Latency:** a group pushed at edge N into an idle block is popped at edge N+1. The first beat (addr 0) is visible after edge N+1, i.e. 2 cycles.
- **Throughput:** one metric per cycle while bm_ready = 1; a sweep takes 16 or 64 cycles.
- **Back-pressure:** while bm_valid & !bm_ready, bm_addr, bm_value and bm_last are held stable.
- **Reset mid-sweep:** an asserted rst (low) at any edge aborts the sweep. The FIFO is flushed and no partial sweep resumes.

## Configuration
- **BMU_SOFT_EN defined:**
  - rx_sym is 18 bits with 3-bit soft samples.
  - Soft metric, range 0..42.
- **BMU_SOFT_EN undefined:**
  - rx_sym is 6 bits, hard decision.
  - Hamming metric, range 0..6; bm_value[5:3] = 0.

## Test plan
- **Hard metric, rate 1/2:**
  - Stimulus: hard build, mode 0, rx_sym = 6'b001010, bm_ready = 1.
  - Response: 16 beats with addr 0..15; addr 0 → 2, addr 10 → 0, addr 5 → 4; bm_last only at addr 15; first beat 2 cycles after the push.
- **Hard metric, rate 1/3, back-to-back:**
  - Stimulus: mode 1, rx_sym = 6'b111111, then a second group pushed during the sweep.
  - Response: 64 beats; addr 0 → 6, addr 63 → 0; the second sweep's addr 0 appears the cycle after addr 63 with no bubble.
- **Back-pressure and FIFO full:**
  - Stimulus: bm_ready = 0, push 4 groups.
  - Response: 3 accepted (1 in sweep, 2 in FIFO); rx_ready low at the 4th; outputs stable on addr 0.
  - Then raise bm_ready: sweeps are emitted in push order.
- **Mid-sweep disturbances:**
  - Stimulus: drop en_bm at addr 7 for 5 cycles, and toggle mode_select mid-sweep.
  - Response: bm_valid is 0 during the gap; resumes at addr 7 with the same value; the sweep length is unchanged.
- **Reset mid-sweep:**
  - Stimulus: rst low at addr 20 with 2 groups queued.
  - Response: all outputs 0 and FIFO empty next cycle; no beats after release until a new push.
- **Soft metric (BMU_SOFT_EN defined):**
  - Stimulus: mode 0, all samples 3'b000.
  - Response: addr 0 → 0, addr 15 → 28, addr 3 → 14.

Source files
------------

// File: rtl/branch_metric_unit_if.sv
// branch_metric_unit_if: symbol-in / metric-out handshake bundle; rx_sym is 18 bits when BMU_SOFT_EN is defined, else 6.
interface branch_metric_unit_if;
`ifdef BMU_SOFT_EN
    localparam int SW = 18;
`else
    localparam int SW = 6;
`endif
    logic          en_bm;
    logic          mode_select;
    logic          rx_valid;
    logic          rx_ready;
    logic [SW-1:0] rx_sym;
    logic          bm_ready;
    logic          bm_valid;
    logic [5:0]    bm_addr;
    logic [5:0]    bm_value;
    logic          bm_last;
    modport master (
        output en_bm, mode_select, rx_valid, rx_sym, bm_ready,
        input  rx_ready, bm_valid, bm_addr, bm_value, bm_last
    );
    modport slave (
        input  en_bm, mode_select, rx_valid, rx_sym, bm_ready,
        output rx_ready, bm_valid, bm_addr, bm_value, bm_last
    );
endinterface

// File: rtl/branch_metric_unit.sv
// branch_metric_unit: radix-4 Viterbi branch metrics, one sweep of codeword hypotheses per received group.
// Define BMU_SOFT_EN for 3-bit soft samples (18-bit rx_sym, metric 0..42); default is hard Hamming metric (0..6).
module branch_metric_unit (
    input  logic                  clk,
    input  logic                  rst,
    branch_metric_unit_if.slave   io_bmu
);
`ifdef BMU_SOFT_EN
    localparam int SW = 18;
`else
    localparam int SW = 6;
`endif
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t        r_state;
    logic [SW-1:0] r_fifo [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          r_rx_ready;
    logic [SW-1:0] r_sym;
    logic          r_mode;
    logic [5:0]    r_addr;
    logic [5:0]    r_value;
    logic          r_valid;
    logic          r_last;
    logic          w_push;
    logic          w_xfer;
    logic          w_load;
    logic          w_sweep_nxt;
    logic [1:0]    w_count_nxt;
    logic [5:0]    w_addr_inc;
    logic [SW-1:0] w_head;

    function automatic logic [5:0] f_metric(input logic [SW-1:0] sym, input logic [5:0] addr, input logic mode);
        logic [5:0] acc;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4 || mode) begin
`ifdef BMU_SOFT_EN
                acc = acc + {3'b0, addr[i] ? 3'd7 - sym[3*i +: 3] : sym[3*i +: 3]};
`else
                acc = acc + {5'b0, addr[i] ^ sym[i]};
`endif
            end
        end
        return acc;
    endfunction

    // Handshake qualifiers; a disabled block neither pushes, pops nor advances.
    always_comb begin
        w_head      = r_fifo[r_rptr];
        w_push      = io_bmu.rx_valid & r_rx_ready & io_bmu.en_bm;
        w_xfer      = r_valid & io_bmu.bm_ready & io_bmu.en_bm;
        w_load      = io_bmu.en_bm & (r_count != 2'd0) & ((r_state == IDLE) | (w_xfer & r_last));
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_load};
        w_sweep_nxt = w_load | ((r_state == SWEEP) & ~(w_xfer & r_last));
        w_addr_inc  = r_addr + 6'd1;
    end

    // Two-entry input FIFO; rx_ready is registered from the next occupancy so it never depends on a pop combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_rx_ready <= 1'b0;
        end else begin
            r_rx_ready <= io_bmu.en_bm & (w_count_nxt != 2'd2);
            r_count    <= w_count_nxt;
            if (w_push) begin
                r_fifo[r_wptr] <= io_bmu.rx_sym;
                r_wptr         <= ~r_wptr;
            end
            if (w_load)
                r_rptr <= ~r_rptr;
        end
    end

    // Sweep FSM with registered beat; a load on the last transfer restarts at addr 0 with no bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sym   <= '0;
            r_mode  <= 1'b0;
            r_addr  <= 6'd0;
            r_value <= 6'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= io_bmu.en_bm & w_sweep_nxt;
            if (w_load) begin
                r_state <= SWEEP;
                r_sym   <= w_head;
                r_mode  <= io_bmu.mode_select;
                r_addr  <= 6'd0;
                r_value <= f_metric(w_head, 6'd0, io_bmu.mode_select);
                r_last  <= 1'b0;
            end else if (w_xfer) begin
                if (r_last) begin
                    r_state <= IDLE;
                end else begin
                    r_addr  <= w_addr_inc;
                    r_value <= f_metric(r_sym, w_addr_inc, r_mode);
                    r_last  <= w_addr_inc == (r_mode ? 6'd63 : 6'd15);
                end
            end
        end
    end

    assign io_bmu.rx_ready = r_rx_ready;
    assign io_bmu.bm_valid = r_valid;
    assign io_bmu.bm_addr  = r_addr;
    assign io_bmu.bm_value = r_value;
    assign io_bmu.bm_last  = r_last;
endmodule

// File: tb/tb_branch_metric_unit.sv
// tb_branch_metric_unit: directed and random stimulus against a queue-based reference of the branch metric unit.
module tb_branch_metric_unit;
`ifdef BMU_SOFT_EN
    localparam int SW = 18;
`else
    localparam int SW = 6;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_checks = 0;
    int n_errs = 0;
    bit started = 0;
    logic [SW-1:0] q [$];
    bit busy = 0;
    bit m_rdy = 0;
    bit m_valid = 0;
    bit m_zero = 1;
    bit m_push = 0;
    bit cur_mode = 0;
    logic [SW-1:0] cur_sym = '0;
    int cur_addr = 0;
    bit ok;
    int v;
    int v7;
    int n_acc;

    branch_metric_unit_if bus();
    branch_metric_unit dut (.clk(clk), .rst(rst), .io_bmu(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lim(input bit m);
        return m ? 63 : 15;
    endfunction

    function automatic int ref_metric(input logic [SW-1:0] s, input int a, input bit m);
        int n;
        int d;
        n = m ? 6 : 4;
        d = 0;
`ifdef BMU_SOFT_EN
        for (int i = 0; i < n; i++) begin
            int smp;
            smp = int'(s[3*i +: 3]);
            d += a[i] ? 7 - smp : smp;
        end
`else
        d = $countones((a ^ int'(s)) & ((1 << n) - 1));
`endif
        return d;
    endfunction

    // Reference: queue of pending groups plus the sweep in progress, advanced once per clock edge.
    initial forever begin
        @(posedge clk);
        started = 1;
        if (!rst) begin
            q.delete();
            busy = 0;
            m_rdy = 0;
            m_valid = 0;
            m_zero = 1;
        end else begin
            m_push = bus.rx_valid && m_rdy && bus.en_bm;
            if (bus.en_bm) begin
                if (m_valid && bus.bm_ready) begin
                    if (cur_addr == lim(cur_mode)) busy = 0;
                    else cur_addr++;
                end
                if (!busy && q.size() > 0) begin
                    cur_sym = q.pop_front();
                    cur_mode = bus.mode_select;
                    cur_addr = 0;
                    busy = 1;
                    m_zero = 0;
                end
                if (m_push) q.push_back(bus.rx_sym);
            end
            m_rdy = bus.en_bm && q.size() < 2;
            m_valid = bus.en_bm && busy;
        end
    end

    // Compare every registered output against the reference away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("rx_ready", int'(bus.rx_ready), int'(m_rdy));
            check("bm_valid", int'(bus.bm_valid), int'(m_valid));
            if (busy || m_zero) begin
                check("bm_addr", int'(bus.bm_addr), busy ? cur_addr : 0);
                check("bm_value", int'(bus.bm_value), busy ? ref_metric(cur_sym, cur_addr, cur_mode) : 0);
                check("bm_last", int'(bus.bm_last), int'(busy && cur_addr == lim(cur_mode)));
            end
        end
    end

    task automatic push_group(input logic [SW-1:0] s, input int tries, output bit acc);
        bit r;
        int i;
        acc = 0;
        i = 0;
        bus.rx_sym = s;
        bus.rx_valid = 1'b1;
        while (i < tries && !acc) begin
            r = bus.rx_ready && bus.en_bm;
            @(negedge clk);
            acc = r;
            i++;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_beat(input int a, input int bound, output int val);
        int i;
        i = 0;
        val = -1;
        while (i < bound && !(bus.bm_valid && int'(bus.bm_addr) == a)) begin
            @(negedge clk);
            i++;
        end
        check($sformatf("beat%0d_found", a), int'(i < bound), 1);
        if (i < bound) val = int'(bus.bm_value);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (i < bound && (busy || q.size() > 0)) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", int'(i < bound), 1);
        @(negedge clk);
    endtask

    initial begin
        bus.en_bm = 1'b1;
        bus.mode_select = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_sym = '0;
        bus.bm_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_ready", int'(bus.rx_ready), 0);
        check("reset_bm_valid", int'(bus.bm_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_rx_ready", int'(bus.rx_ready), 1);

        // Rate 1/2 sweep with first-beat latency
        bus.bm_ready = 1'b1;
        push_group(SW'(6'b001010), 5, ok);
        check("t1_push", int'(ok), 1);
        check("t1_gap", int'(bus.bm_valid), 0);
        @(negedge clk);
        check("t1_first_valid", int'(bus.bm_valid), 1);
        check("t1_first_addr", int'(bus.bm_addr), 0);
`ifndef BMU_SOFT_EN
        check("t1_addr0", int'(bus.bm_value), 2);
        wait_beat(5, 20, v);
        check("t1_addr5", v, 4);
        wait_beat(10, 20, v);
        check("t1_addr10", v, 0);
`endif
        wait_beat(15, 20, v);
        check("t1_last15", int'(bus.bm_last), 1);
        wait_idle(50);

        // Rate 1/3 back-to-back sweeps
        bus.mode_select = 1'b1;
        push_group(SW'(6'b111111), 5, ok);
        wait_beat(0, 10, v);
`ifndef BMU_SOFT_EN
        check("t2_addr0", v, 6);
`endif
        push_group(SW'($urandom), 5, ok);
        check("t2_push2", int'(ok), 1);
        wait_beat(63, 100, v);
`ifndef BMU_SOFT_EN
        check("t2_addr63", v, 0);
`endif
        check("t2_last63", int'(bus.bm_last), 1);
        @(negedge clk);
        check("t2_b2b_valid", int'(bus.bm_valid), 1);
        check("t2_b2b_addr", int'(bus.bm_addr), 0);
        wait_idle(100);

`ifdef BMU_SOFT_EN
        // Soft metric with all samples strong zero
        bus.mode_select = 1'b0;
        push_group('0, 5, ok);
        wait_beat(0, 10, v);
        check("s_addr0", v, 0);
        wait_beat(3, 10, v);
        check("s_addr3", v, 14);
        wait_beat(15, 20, v);
        check("s_addr15", v, 28);
        wait_idle(50);
`endif

        // Back-pressure fills the FIFO
        bus.mode_select = 1'b0;
        bus.bm_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            push_group(SW'($urandom), 3, ok);
            n_acc += int'(ok);
        end
        check("t3_accepted", n_acc, 3);
        check("t3_rx_ready_full", int'(bus.rx_ready), 0);
        repeat (3) @(negedge clk);
        check("t3_hold_valid", int'(bus.bm_valid), 1);
        check("t3_hold_addr", int'(bus.bm_addr), 0);
        bus.bm_ready = 1'b1;
        wait_idle(100);

        // Enable gap and mode toggle mid-sweep
        push_group(SW'($urandom), 5, ok);
        push_group(SW'($urandom), 5, ok);
        wait_beat(7, 20, v7);
        bus.en_bm = 1'b0;
        bus.mode_select = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_gap_valid", int'(bus.bm_valid), 0);
        repeat (3) @(negedge clk);
        bus.en_bm = 1'b1;
        wait_beat(7, 5, v);
        check("t4_resume_val", v, v7);
        wait_beat(15, 20, v);
        check("t4_last15", int'(bus.bm_last), 1);
        wait_idle(150);

        // Reset mid-sweep with two groups queued
        push_group(SW'($urandom), 5, ok);
        push_group(SW'($urandom), 5, ok);
        push_group(SW'($urandom), 5, ok);
        wait_beat(20, 80, v);
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid", int'(bus.bm_valid), 0);
        check("t5_addr", int'(bus.bm_addr), 0);
        check("t5_value", int'(bus.bm_value), 0);
        check("t5_last", int'(bus.bm_last), 0);
        check("t5_rx_ready", int'(bus.rx_ready), 0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_quiet", int'(bus.bm_valid), 0);
        end

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            bus.rx_valid = 1'($urandom_range(0, 1));
            bus.rx_sym = SW'($urandom);
            bus.bm_ready = $urandom_range(0, 3) != 0;
            bus.en_bm = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 15) == 0) bus.mode_select = ~bus.mode_select;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        bus.en_bm = 1'b1;
        bus.bm_ready = 1'b1;
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
